led_trail_pwm: RTL and testbench
================================

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 Parameter: PWM_BITS, 8, width of the brightness value and of the PWM counter.
REQ-002 Parameter: DECAY_DIV, 1_250_000, clk cycles between decay ticks (25 ms at 50 MHz); legal range >= 2.
REQ-003 Parameter: DECAY_STEP, 32, amount subtracted from each non-lit channel's brightness per decay tick; legal range 1..2^PWM_BITS-1.
REQ-004 Port: clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: enable  input  1  synchronous run enable; low blanks the outputs.
REQ-007 Port: led_in  input  8  one-hot chaser pattern from the upstream chaser stage; any bit pattern is legal.
REQ-008 Port: led_out  output  8  PWM-modulated LED drive with a fading trail.
REQ-009 Port: pwm_wrap  output  1  one-cycle pulse on the cycle the PWM counter wraps from MAX to 0.

Function
REQ-010 MAX SHALL equal 2^PWM_BITS-1; all brightness and counter arithmetic SHALL be PWM_BITS wide and unsigned.
REQ-011 PWM counter cnt SHALL increment by 1 every clk cycle while enable=1 and wrap MAX->0.
REQ-012 pwm_wrap SHALL be registered and high for exactly the one cycle following the cycle in which cnt==MAX; period 2^PWM_BITS cycles.
REQ-013 Prescaler SHALL count 0..DECAY_DIV-1 while enable=1; decay_tick is asserted on the cycle the prescaler equals DECAY_DIV-1, after which the prescaler returns to 0.
REQ-014 Per channel i, every cycle with enable=1: if led_in[i]=1, bright[i] SHALL load MAX; else if decay_tick, bright[i] SHALL load bright[i]-DECAY_STEP saturated at 0; else hold.
REQ-015 led_in[i]=1 SHALL take priority over a coincident decay_tick (the channel loads MAX, with no decrement).
REQ-016 Each channel SHALL hold a shadow copy shadow[i], loaded from bright[i] only on the cycle cnt==MAX, so that a duty change never takes effect mid-period.
REQ-017 led_out[i] SHALL be registered: next value = 1 if shadow[i]==MAX, else (cnt < shadow[i]); shadow 0 gives constant 0, shadow MAX gives constant 1.
REQ-018 Latency: a led_in[i] rise SHALL reach led_out[i]=1 no later than the first cycle after the next PWM wrap, i.e. at most 2^PWM_BITS+2 cycles.
REQ-019 enable=0 SHALL, on the next edge, clear cnt, prescaler, all bright, all shadow, led_out and pwm_wrap to 0 and hold them at 0 while low; led_in is ignored.
REQ-020 Re-assertion of enable SHALL restart from the all-zero state, with cnt=0 on the first enabled cycle.

Reset
REQ-021 rst=1 SHALL asynchronously force cnt=0, prescaler=0, bright[*]=0, shadow[*]=0, led_out=8'h00, pwm_wrap=0.
REQ-022 Release of rst SHALL be followed by normal operation on the first rising clk edge at which rst=0; reset asserted mid-period SHALL abort the period with no partial pulse after the reset.

Structure
REQ-023 A shared package SHALL hold PWM_BITS, the default DECAY_DIV and DECAY_STEP values, and the LED count constant (8) used by the chaser and this stage.
REQ-024 One sub-module, led_pwm_channel, SHALL implement the REQ-014..017 per-channel logic (bright, shadow, compare) and be instantiated 8 times; the top SHALL own cnt, the prescaler and pwm_wrap.

Verification (DECAY_DIV=4, DECAY_STEP=64, PWM_BITS=8 for simulation)
REQ-025 Reset then enable=1 and led_in=8'h00 -> led_out=8'h00 for 1024 cycles; pwm_wrap pulses every 256 cycles.
REQ-026 led_in=8'h01 held -> after the next wrap, led_out[0]=1 constantly and bits 7:1 stay 0.
REQ-027 led_in 8'h01 then 8'h00 -> bright[0] steps 255, 191, 127, 63, 0 on successive decay ticks; the measured high count of led_out[0] in each full period equals the shadow value loaded at its start.
REQ-028 led_in shifted 8'h01->8'h02->8'h04 every 64 cycles -> trailing channels show a monotonically non-increasing duty and the lit channel shows 100 %; a coincident decay_tick on the lit channel does not decrement it.
REQ-029 enable dropped mid-period with bright[0]=255 -> next cycle led_out=0, pwm_wrap=0, cnt=0; after re-enable, led_out stays 0 until led_in reloads.
REQ-030 rst pulsed asynchronously mid-period (between edges) -> all outputs 0 immediately, without waiting for a clk edge; normal restart from cnt=0 after release.

Source files
------------

// File: rtl/led_trail_pwm_pkg.sv
// Shared constants for the LED chaser / trail-PWM stages.
// Defaults here are used by both the chaser and the trail-PWM stage.
package led_trail_pwm_pkg;

   localparam int unsigned LED_N          = 8;
   localparam int unsigned PWM_BITS_DEF   = 8;
   localparam int unsigned DECAY_DIV_DEF  = 1_250_000;
   localparam int unsigned DECAY_STEP_DEF = 32;

   // Width of a counter running 0..div-1, never narrower than one bit.
   function automatic int unsigned presc_width(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One trail channel: brightness with saturating decay, period-aligned
// shadow duty and the registered PWM compare.
module led_pwm_channel
   import led_trail_pwm_pkg::*;
#(
   parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
   parameter int unsigned DECAY_STEP = DECAY_STEP_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                led_in,
   input  logic                decay_tick,
   input  logic                cnt_max,
   input  logic [PWM_BITS-1:0] cnt,
   output logic                led_out
);

   localparam logic [PWM_BITS-1:0] MAX  = '1;
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

   logic [PWM_BITS-1:0] bright;
   logic [PWM_BITS-1:0] shadow;
   logic [PWM_BITS-1:0] bright_nxt;
   logic                led_nxt;

   // A lit input wins over a coincident decay tick.
   always_comb begin
      bright_nxt = bright;
      if (led_in) begin
         bright_nxt = MAX;
      end else if (decay_tick) begin
         bright_nxt = (bright > STEP) ? (bright - STEP) : '0;
      end
   end

   // Full-scale duty is forced high so the output never drops on cnt==MAX.
   always_comb begin
      led_nxt = (shadow == MAX) || (cnt < shadow);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bright  <= '0;
         shadow  <= '0;
         led_out <= 1'b0;
      end else if (!enable) begin
         bright  <= '0;
         shadow  <= '0;
         led_out <= 1'b0;
      end else begin
         bright  <= bright_nxt;
         if (cnt_max) begin
            shadow <= bright;
         end
         led_out <= led_nxt;
      end
   end

endmodule

// File: rtl/led_trail_pwm.sv
// Fading-trail PWM stage behind the LED chaser: shared PWM counter,
// decay prescaler and wrap pulse, plus one channel per LED.
module led_trail_pwm
   import led_trail_pwm_pkg::*;
#(
   parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
   parameter int unsigned DECAY_DIV  = DECAY_DIV_DEF,
   parameter int unsigned DECAY_STEP = DECAY_STEP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [LED_N-1:0] led_in,
   output logic [LED_N-1:0] led_out,
   output logic             pwm_wrap
);

   localparam int unsigned         PSW      = presc_width(DECAY_DIV);
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [PSW-1:0]      PRE_LAST = PSW'(DECAY_DIV - 1);

   logic [PWM_BITS-1:0] cnt;
   logic [PSW-1:0]      presc;
   logic                cnt_max;
   logic                decay_tick;

   always_comb begin
      cnt_max    = (cnt == MAX);
      decay_tick = enable && (presc == PRE_LAST);
   end

   // Counter, prescaler and wrap pulse all collapse to zero while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         presc    <= '0;
         pwm_wrap <= 1'b0;
      end else if (!enable) begin
         cnt      <= '0;
         presc    <= '0;
         pwm_wrap <= 1'b0;
      end else begin
         cnt      <= cnt + PWM_BITS'(1);
         presc    <= decay_tick ? '0 : (presc + PSW'(1));
         pwm_wrap <= cnt_max;
      end
   end

   for (genvar i = 0; i < LED_N; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .enable     (enable),
         .led_in     (led_in[i]),
         .decay_tick (decay_tick),
         .cnt_max    (cnt_max),
         .cnt        (cnt),
         .led_out    (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: period-level model of brightness, shadow duty
// and wrap timing, checked every cycle, plus hand-computed duty counts.
module tb_led_trail_pwm;

   localparam int unsigned DD   = 4;
   localparam int unsigned DS   = 64;
   localparam int          MAXV = 255;
   localparam int          PER  = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] led_in = 8'h00;
   logic [7:0] led_out;
   logic       pwm_wrap;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   led_trail_pwm #(
      .PWM_BITS   (8),
      .DECAY_DIV  (DD),
      .DECAY_STEP (DS)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .led_in   (led_in),
      .led_out  (led_out),
      .pwm_wrap (pwm_wrap)
   );

   // Model: phase = position inside the PWM period, ticks every DD cycles,
   // duty of a period = brightness sampled at its last cycle.
   int         m_phase = 0;
   int         m_tick_ph = 0;
   int         m_br [8] = '{default: 0};
   int         m_duty [8] = '{default: 0};
   logic [7:0] m_led = 8'h00;
   logic       m_wrap = 1'b0;
   logic [7:0] nl;
   bit         tick;

   always @(posedge clk or posedge rst) begin
      if (rst || !enable) begin
         m_phase = 0; m_tick_ph = 0; m_led = 8'h00; m_wrap = 1'b0;
         for (int i = 0; i < 8; i++) begin m_br[i] = 0; m_duty[i] = 0; end
      end else begin
         tick = (m_tick_ph == DD - 1);
         for (int i = 0; i < 8; i++)
            nl[i] = (m_duty[i] == MAXV) || (m_phase < m_duty[i]);
         if (m_phase == PER - 1)
            for (int i = 0; i < 8; i++) m_duty[i] = m_br[i];
         for (int i = 0; i < 8; i++) begin
            if (led_in[i]) m_br[i] = MAXV;
            else if (tick) m_br[i] = (m_br[i] > DS) ? m_br[i] - DS : 0;
         end
         m_wrap    = (m_phase == PER - 1);
         m_phase   = (m_phase + 1) % PER;
         m_tick_ph = (m_tick_ph + 1) % DD;
         m_led     = nl;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("led_out_model", led_out, m_led);
      chk("pwm_wrap_model", pwm_wrap, m_wrap);
   end

   task automatic wait_phase(input int v);
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         if (m_phase == v) return;
      end
      checks++; errors++;
      $display("FAIL wait_phase: phase %0d never reached at %0t", v, $time);
   endtask

   task automatic cycles_to_wrap(input string name, input int exp);
      int n;
      n = 0;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         n++;
         if (pwm_wrap) break;
      end
      chk(name, n, exp);
   endtask

   int rel_ph [5] = '{253, 249, 245, 241, 237};
   int exp_hi [5] = '{256, 191, 127, 63, 0};
   int hi;
   int wraps;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_led_out", led_out, 0);
      chk("reset_pwm_wrap", pwm_wrap, 0);
      rst = 1'b0;
      @(negedge clk);
      enable = 1'b1;

      // Idle chaser: dark outputs, wrap every 256 cycles
      wraps = 0; hi = 0;
      for (int k = 0; k < 1024; k++) begin
         @(negedge clk);
         wraps += int'(pwm_wrap);
         hi += int'(led_out != 8'h00);
      end
      chk("idle_wrap_count", wraps, 4);
      chk("idle_lit_cycles", hi, 0);

      // Held channel 0 -> constant full-on after the next wrap
      led_in = 8'h01;
      wait_phase(0); wait_phase(0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("steady_ch0", led_out, 8'h01);
      end

      // Release at chosen phases: duty of next period = decayed brightness
      for (int t = 0; t < 5; t++) begin
         led_in = 8'h01;
         wait_phase(rel_ph[t]);
         led_in = 8'h00;
         wait_phase(0);
         hi = 0;
         for (int k = 0; k < PER; k++) begin
            @(negedge clk);
            hi += int'(led_out[0]);
         end
         chk("decay_duty", hi, exp_hi[t]);
      end

      // Shifting chaser with a fading trail
      for (int r = 0; r < 4; r++) begin
         led_in = 8'h01; repeat (64) @(negedge clk);
         led_in = 8'h02; repeat (64) @(negedge clk);
         led_in = 8'h04; repeat (64) @(negedge clk);
      end

      // Enable dropped mid-period with channel 0 fully lit
      led_in = 8'h01;
      wait_phase(0); wait_phase(0); wait_phase(100);
      chk("pre_disable_ch0", int'(led_out[0]), 1);
      enable = 1'b0;
      led_in = 8'hff;
      @(negedge clk);
      chk("disable_led_out", led_out, 0);
      chk("disable_pwm_wrap", pwm_wrap, 0);
      repeat (10) @(negedge clk);
      led_in = 8'h00;
      enable = 1'b1;
      cycles_to_wrap("reenable_first_wrap", 256);
      hi = 0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         hi += int'(led_out != 8'h00);
      end
      chk("reenable_dark", hi, 0);

      // Asynchronous reset between edges
      led_in = 8'h01;
      wait_phase(0); wait_phase(0); wait_phase(100);
      chk("pre_reset_ch0", int'(led_out[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_led_out", led_out, 0);
      chk("async_rst_pwm_wrap", pwm_wrap, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cycles_to_wrap("post_reset_first_wrap", 256);
      repeat (300) @(negedge clk);
      chk("post_reset_ch0", led_out, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
